// File: rtl/spybuffer_event_reader.sv
// spybuffer_event_reader: drains one SpyBuffer, checks header/data/footer framing,
// and forwards events on a valid/ready stream with event and error counters.
module spybuffer_event_reader #(
   parameter int         DATA_WIDTH      = 65,
   parameter int         MAX_EVENT_WORDS = 1024,
   parameter logic [7:0] HEADER_TAG      = 8'hAB,
   parameter logic [7:0] FOOTER_TAG      = 8'hCD
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_read_data,
   output logic                  fifo_read_enable,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic [31:0]           event_count,
   output logic [15:0]           error_count,
   output logic                  in_event
);
   localparam int            CW      = $clog2(MAX_EVENT_WORDS + 2);
   localparam logic [CW-1:0] MAXW    = CW'(MAX_EVENT_WORDS);
   localparam logic [0:0]    S_IDLE  = 1'b0;
   localparam logic [0:0]    S_EVENT = 1'b1;

   logic [2:0][DATA_WIDTH:0] mem_q, mem_d;
   logic [1:0]               wp_q, wp_d, rp_q, rp_d, cnt_q, cnt_d;
   logic                     rd_q, rd_d, ovf_q, ovf_d;
   logic [0:0]               state_q, state_d;
   logic [CW-1:0]            wcnt_q, wcnt_d;
   logic [31:0]              ev_q, ev_d;
   logic [15:0]              err_q, err_d;
   logic [7:0]               tag;
   logic                     flag, hdr, ftr, enq, last, err, pop;

   assign out_valid        = cnt_q != 2'd0;
   assign {out_last, out_data} = out_valid ? mem_q[rp_q] : '0;
   // Slots are reserved at request time, so an inflight word always has room.
   assign fifo_read_enable = reset_n && !fifo_empty && (3'(cnt_q) + 3'(rd_q)) < 3'd3;
   assign event_count      = ev_q;
   assign error_count      = err_q;
   assign in_event         = state_q == S_EVENT;

   always_comb begin
      flag    = fifo_read_data[DATA_WIDTH-1];
      tag     = fifo_read_data[DATA_WIDTH-2 -: 8];
      hdr     = flag && tag == HEADER_TAG;
      ftr     = flag && tag == FOOTER_TAG;
      state_d = state_q;
      wcnt_d  = wcnt_q;
      ovf_d   = ovf_q;
      enq     = 1'b0;
      last    = 1'b0;
      err     = 1'b0;
      if (rd_q) begin
         if (hdr) begin
            enq     = 1'b1;
            err     = state_q == S_EVENT;
            state_d = S_EVENT;
            wcnt_d  = CW'(1);
            ovf_d   = 1'b0;
         end else if (state_q == S_EVENT && (!flag || ftr)) begin
            enq     = 1'b1;
            last    = ftr;
            wcnt_d  = (wcnt_q > MAXW) ? wcnt_q : wcnt_q + CW'(1);
            state_d = ftr ? S_IDLE : S_EVENT;
         end else begin
            err = 1'b1;
         end
      end
      if (enq && wcnt_d > MAXW && !ovf_d) begin
         err   = 1'b1;
         ovf_d = 1'b1;
      end
      pop   = out_valid && out_ready;
      mem_d = mem_q;
      if (enq) mem_d[wp_q] = {last, fifo_read_data};
      wp_d  = enq ? (wp_q == 2'd2 ? 2'd0 : wp_q + 2'd1) : wp_q;
      rp_d  = pop ? (rp_q == 2'd2 ? 2'd0 : rp_q + 2'd1) : rp_q;
      cnt_d = cnt_q + 2'(enq) - 2'(pop);
      rd_d  = fifo_read_enable;
      ev_d  = ev_q + 32'(pop && out_last);
      err_d = (err && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         ovf_q   <= 1'b0;
         ev_q    <= '0;
         err_q   <= '0;
      end else begin
         mem_q   <= mem_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ovf_q   <= ovf_d;
         ev_q    <= ev_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_spybuffer_event_reader.sv
// tb_spybuffer_event_reader: scoreboard bench; dut_a uses the default event limit, dut_b a limit of 4.
module tb_spybuffer_event_reader;
   localparam int DW = 65;

   logic clock = 1'b0, reset_n = 1'b0, sel = 1'b0, out_ready = 1'b1;
   logic src_empty = 1'b1, re_s = 1'b0, clr_stats = 1'b0, chk_occ = 1'b0;
   logic [DW-1:0] rd_data = '0;
   logic [DW-1:0] src_q[$];
   logic [DW:0]   exp_q[$];
   logic re_a, re_b, ov_a, ov_b, ol_a, ol_b, ie_a, ie_b, re, ov, ol, ie;
   logic [DW-1:0] od_a, od_b, od;
   logic [31:0] ec_a, ec_b, ec;
   logic [15:0] er_a, er_b, er;
   int checks = 0, passed = 0, mon_checks = 0, mon_passed = 0;
   int src_idx = 0, mon_idx = 0, cyc = 0;
   int first_re = -1, first_ov = -1, last_cyc = -1, ov_cycles = 0, outstanding = 0, occ_bad = 0;
   bit stall_prev = 0;
   logic [DW:0] held = '0;

   always #5 clock = ~clock;

   spybuffer_event_reader dut_a (
      .clock(clock), .reset_n(reset_n), .fifo_empty(src_empty | sel), .fifo_read_data(rd_data),
      .fifo_read_enable(re_a), .out_data(od_a), .out_valid(ov_a), .out_last(ol_a),
      .out_ready(out_ready), .event_count(ec_a), .error_count(er_a), .in_event(ie_a));

   spybuffer_event_reader #(.MAX_EVENT_WORDS(4)) dut_b (
      .clock(clock), .reset_n(reset_n), .fifo_empty(src_empty | !sel), .fifo_read_data(rd_data),
      .fifo_read_enable(re_b), .out_data(od_b), .out_valid(ov_b), .out_last(ol_b),
      .out_ready(out_ready), .event_count(ec_b), .error_count(er_b), .in_event(ie_b));

   always_comb begin
      re = sel ? re_b : re_a;
      ov = sel ? ov_b : ov_a;
      ol = sel ? ol_b : ol_a;
      ie = sel ? ie_b : ie_a;
      od = sel ? od_b : od_a;
      ec = sel ? ec_b : ec_a;
      er = sel ? er_b : er_a;
   end

   function automatic logic [DW-1:0] hdr(input int n);
      return {1'b1, 8'hAB, 56'(n)};
   endfunction
   function automatic logic [DW-1:0] dat(input int n);
      return {1'b0, 64'(n)};
   endfunction
   function automatic logic [DW-1:0] ftr(input int n);
      return {1'b1, 8'hCD, 56'(n)};
   endfunction

   // SpyBuffer model: one-cycle read latency; a stray header sits on the bus when no read is due.
   always @(posedge clock) begin
      if (reset_n && re_s) begin
         rd_data <= src_q[src_idx];
         src_idx++;
      end else begin
         rd_data <= hdr(16'hBAD);
      end
      if (!reset_n) src_idx = src_q.size();
      src_empty <= src_idx == src_q.size();
   end

   always @(negedge clock) begin
      cyc++;
      re_s = re;
      if (clr_stats) begin
         first_re = -1; first_ov = -1; last_cyc = -1; ov_cycles = 0; occ_bad = 0;
      end
      if (!reset_n) begin
         stall_prev = 0;
         outstanding = 0;
         mon_idx = exp_q.size();
      end else begin
         if (stall_prev) begin
            mon_checks++;
            if (!ov || {ol, od} !== held) $display("FAIL stable: got valid=%b word=%h, want valid=1 word=%h", ov, {ol, od}, held);
            else mon_passed++;
         end
         if (ov && out_ready) begin
            mon_checks++;
            if (mon_idx >= exp_q.size()) $display("FAIL unexpected_word: got %h, want none", {ol, od});
            else if ({ol, od} !== exp_q[mon_idx]) $display("FAIL word: got %h, want %h", {ol, od}, exp_q[mon_idx]);
            else mon_passed++;
            mon_idx++;
            if (ol) last_cyc = cyc;
         end
         if (re && first_re < 0) first_re = cyc;
         if (ov) begin
            ov_cycles++;
            if (first_ov < 0) first_ov = cyc;
         end
         if (chk_occ) begin
            if (outstanding >= 3 && re) occ_bad++;
            outstanding += (re ? 1 : 0) - ((ov && out_ready) ? 1 : 0);
         end else begin
            outstanding = 0;
         end
         stall_prev = ov && !out_ready;
         held = {ol, od};
      end
   end

   task automatic push(input logic [DW-1:0] w, input bit fwd);
      src_q.push_back(w);
      if (fwd) exp_q.push_back({w[DW-1] && w[DW-2 -: 8] == 8'hCD, w});
   endtask

   task automatic clear_stats();
      @(negedge clock); #2 clr_stats = 1'b1;
      @(negedge clock); #2 clr_stats = 1'b0;
   endtask

   task automatic run_idle(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock); #2;
         if (mon_idx >= exp_q.size() && src_empty && !ov && !re) begin
            ok = 1;
            break;
         end
      end
      repeat (3) @(negedge clock);
      #2;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      #2;
      checks++; if ({re, ov, ol, ie} !== 4'b0) $display("FAIL reset_ctl: got %b, want 0000", {re, ov, ol, ie}); else passed++;
      checks++; if (od !== '0) $display("FAIL reset_data: got %h, want 0", od); else passed++;
      checks++; if (ec !== 32'd0) $display("FAIL reset_events: got %0d, want 0", ec); else passed++;
      checks++; if (er !== 16'd0) $display("FAIL reset_errors: got %0d, want 0", er); else passed++;
      reset_n = 1'b1;
   endtask

   task automatic test_clean();
      bit ok;
      clear_stats();
      push(hdr(1), 1); push(dat(11), 1); push(dat(12), 1); push(dat(13), 1); push(ftr(1), 1);
      run_idle(100, ok);
      checks++; if (!ok) $display("FAIL clean_drain: got timeout, want idle"); else passed++;
      checks++; if (ec !== 32'd1) $display("FAIL clean_events: got %0d, want 1", ec); else passed++;
      checks++; if (er !== 16'd0) $display("FAIL clean_errors: got %0d, want 0", er); else passed++;
      checks++; if (ie !== 1'b0) $display("FAIL clean_in_event: got %b, want 0", ie); else passed++;
      checks++; if (first_ov - first_re != 2) $display("FAIL clean_latency: got %0d, want 2", first_ov - first_re); else passed++;
      checks++; if (last_cyc - first_ov != 4) $display("FAIL clean_throughput: got %0d, want 4", last_cyc - first_ov); else passed++;
      checks++; if (ov_cycles != 5) $display("FAIL clean_valid_cycles: got %0d, want 5", ov_cycles); else passed++;
   endtask

   task automatic test_orphans();
      bit ok;
      clear_stats();
      push(dat(21), 0); push(dat(22), 0); push(ftr(2), 0);
      run_idle(100, ok);
      checks++; if (!ok) $display("FAIL orphan_drain: got timeout, want idle"); else passed++;
      checks++; if (ov_cycles != 0) $display("FAIL orphan_valid: got %0d valid cycles, want 0", ov_cycles); else passed++;
      checks++; if (er !== 16'd3) $display("FAIL orphan_errors: got %0d, want 3", er); else passed++;
      checks++; if (ie !== 1'b0) $display("FAIL orphan_in_event: got %b, want 0", ie); else passed++;
   endtask

   task automatic test_nested();
      bit ok;
      clear_stats();
      push(hdr(3), 1); push(dat(31), 1); push(hdr(4), 1); push(dat(41), 1); push(ftr(4), 1);
      run_idle(100, ok);
      checks++; if (!ok) $display("FAIL nested_drain: got timeout, want idle"); else passed++;
      checks++; if (ov_cycles != 5) $display("FAIL nested_valid_cycles: got %0d, want 5", ov_cycles); else passed++;
      checks++; if (er !== 16'd4) $display("FAIL nested_errors: got %0d, want 4", er); else passed++;
      checks++; if (ec !== 32'd2) $display("FAIL nested_events: got %0d, want 2", ec); else passed++;
   endtask

   task automatic test_back_to_back();
      bit ok = 0;
      clear_stats();
      chk_occ = 1'b1;
      push(hdr(5), 1);
      for (int i = 0; i < 8; i++) push(dat(50 + i), 1);
      push(ftr(5), 1);
      for (int i = 0; i < 300; i++) begin
         @(posedge clock); #1 out_ready = ~out_ready;
         if (mon_idx >= exp_q.size() && src_empty && !ov && !re && i > 4) begin
            ok = 1;
            break;
         end
      end
      @(posedge clock); #1 out_ready = 1'b1;
      repeat (3) @(negedge clock);
      #2 chk_occ = 1'b0;
      checks++; if (!ok) $display("FAIL bp_drain: got timeout, want idle"); else passed++;
      checks++; if (mon_idx != exp_q.size()) $display("FAIL bp_count: got %0d consumed, want %0d", mon_idx, exp_q.size()); else passed++;
      checks++; if (occ_bad != 0) $display("FAIL bp_read_when_full: got %0d, want 0", occ_bad); else passed++;
      checks++; if (ec !== 32'd3) $display("FAIL bp_events: got %0d, want 3", ec); else passed++;
      checks++; if (er !== 16'd4) $display("FAIL bp_errors: got %0d, want 4", er); else passed++;
   endtask

   task automatic test_overlength();
      bit ok;
      @(negedge clock); #2 sel = 1'b1;
      clear_stats();
      push(hdr(6), 1); push(dat(61), 1); push(dat(62), 1); push(ftr(6), 1);
      run_idle(100, ok);
      checks++; if (!ok) $display("FAIL ovl_limit_drain: got timeout, want idle"); else passed++;
      checks++; if (er !== 16'd0) $display("FAIL ovl_at_limit_errors: got %0d, want 0", er); else passed++;
      clear_stats();
      push(hdr(7), 1);
      for (int i = 0; i < 4; i++) push(dat(70 + i), 1);
      push(ftr(7), 1);
      run_idle(100, ok);
      checks++; if (!ok) $display("FAIL ovl_drain: got timeout, want idle"); else passed++;
      checks++; if (ov_cycles != 6) $display("FAIL ovl_valid_cycles: got %0d, want 6", ov_cycles); else passed++;
      checks++; if (er !== 16'd1) $display("FAIL ovl_errors: got %0d, want 1", er); else passed++;
      checks++; if (ec !== 32'd2) $display("FAIL ovl_events: got %0d, want 2", ec); else passed++;
      @(negedge clock); #2 sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen = 0;
      clear_stats();
      push(hdr(8), 1); push(dat(81), 1); push(dat(82), 1);
      run_idle(100, ok);
      @(posedge clock); #1 out_ready = 1'b0;
      push(dat(83), 0);
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock); #2 seen = ov;
      end
      checks++; if (!seen || ie !== 1'b1) $display("FAIL mid_setup: got valid=%b in_event=%b, want 1 1", seen, ie); else passed++;
      @(posedge clock); #3 reset_n = 1'b0;
      #1;
      checks++; if ({re, ov, ol, ie} !== 4'b0) $display("FAIL mid_reset_ctl: got %b, want 0000", {re, ov, ol, ie}); else passed++;
      checks++; if (od !== '0) $display("FAIL mid_reset_data: got %h, want 0", od); else passed++;
      checks++; if (ec !== 32'd0 || er !== 16'd0) $display("FAIL mid_reset_counts: got %0d/%0d, want 0/0", ec, er); else passed++;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      out_ready = 1'b1;
      clear_stats();
      push(hdr(9), 1); push(dat(91), 1); push(dat(92), 1); push(ftr(9), 1);
      run_idle(100, ok);
      checks++; if (!ok) $display("FAIL mid_after_drain: got timeout, want idle"); else passed++;
      checks++; if (ec !== 32'd1) $display("FAIL mid_after_events: got %0d, want 1", ec); else passed++;
      checks++; if (er !== 16'd0) $display("FAIL mid_after_errors: got %0d, want 0", er); else passed++;
   endtask

   initial begin
      test_reset();
      test_clean();
      test_orphans();
      test_nested();
      test_back_to_back();
      test_overlength();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed + mon_passed, checks + mon_checks);
      $finish;
   end
endmodule
